// File: rtl/uart_rx_param_if.sv
// Word output handshake of the UART receiver: received word, per-word error
// flags and valid/ready. The receiver drives the master side.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data_out, valid, frame_err, parity_err, overrun,
    input  ready
  );

  modport slave (
    input  data_out, valid, frame_err, parity_err, overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// registered word output with framing/parity/overrun flags.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  output logic             busy,
  uart_rx_param_if.master  rxo
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
  } state_t;

  state_t               state;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 stp;
  logic [DATA_BITS-1:0] shreg;
  logic                 fe_acc, pe_acc;
  logic                 load;
  logic                 bit_end;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta        <= 1'b1;
      rxs            <= 1'b1;
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      stp            <= 1'b0;
      shreg          <= '0;
      fe_acc         <= 1'b0;
      pe_acc         <= 1'b0;
      load           <= 1'b0;
      rxo.data_out   <= '0;
      rxo.valid      <= 1'b0;
      rxo.frame_err  <= 1'b0;
      rxo.parity_err <= 1'b0;
      rxo.overrun    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      load    <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt    <= '0;
          idx    <= '0;
          stp    <= 1'b0;
          fe_acc <= 1'b0;
          pe_acc <= 1'b0;
          if (!rxs) state <= S_START;
        end
        S_START: begin
          // A start bit that is gone by mid-bit was a glitch
          if (cnt == CW'(HALF)) begin
            cnt   <= '0;
            state <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == IW'(DATA_BITS - 1))
              state <= (PARITY != 0) ? S_PAR : S_STOP;
            else
              idx <= idx + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PAR: begin
          if (bit_end) begin
            cnt    <= '0;
            pe_acc <= ((^shreg) ^ rxs) != (PARITY == 1);
            state  <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt    <= '0;
            fe_acc <= fe_acc | ~rxs;
            if (stp == 1'(STOP_BITS - 1)) begin
              load  <= 1'b1;
              state <= (fe_acc | ~rxs) ? S_BREAK : S_IDLE;
            end else begin
              stp <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BREAK: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Load beats a simultaneous accept; the old word counts as consumed
      if (load) begin
        rxo.data_out   <= shreg;
        rxo.frame_err  <= fe_acc;
        rxo.parity_err <= pe_acc;
        rxo.valid      <= 1'b1;
        rxo.overrun    <= rxo.valid & ~rxo.ready;
      end else if (rxo.valid && rxo.ready) begin
        rxo.valid      <= 1'b0;
        rxo.frame_err  <= 1'b0;
        rxo.parity_err <= 1'b0;
        rxo.overrun    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (no parity, even parity,
// two stop bits) at 16 clocks per bit, sharing one bit-serial driver.
module tb_uart_rx_param;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_drv = 1'b1;
  int   sel = 0;
  logic rx0, rx1, rx2;
  logic busy0, busy1, busy2;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign rx0 = (sel == 0) ? rx_drv : 1'b1;
  assign rx1 = (sel == 1) ? rx_drv : 1'b1;
  assign rx2 = (sel == 2) ? rx_drv : 1'b1;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_if #(.DATA_BITS(8)) if2 ();

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst_n(rst_n), .rx(rx0), .busy(busy0), .rxo(if0));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u1 (.clk(clk), .rst_n(rst_n), .rx(rx1), .busy(busy1), .rxo(if1));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
    u2 (.clk(clk), .rst_n(rst_n), .rx(rx2), .busy(busy2), .rxo(if2));

  // Word monitor: counts valid rises / high cycles and captures each new word
  logic [2:0] vv;
  logic [2:0] pv = 3'b000;
  int         rise [3] = '{0, 0, 0};
  int         vcyc [3] = '{0, 0, 0};
  logic [7:0] cap_d [3];
  logic       cap_fe [3];
  logic       cap_pe [3];
  assign vv = {if2.valid, if1.valid, if0.valid};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vv[k]) begin
        vcyc[k]++;
        if (!pv[k]) begin
          rise[k]++;
          case (k)
            0:       begin cap_d[k] = if0.data_out; cap_fe[k] = if0.frame_err; cap_pe[k] = if0.parity_err; end
            1:       begin cap_d[k] = if1.data_out; cap_fe[k] = if1.frame_err; cap_pe[k] = if1.parity_err; end
            default: begin cap_d[k] = if2.data_out; cap_fe[k] = if2.frame_err; cap_pe[k] = if2.parity_err; end
          endcase
        end
      end
    end
    pv = vv;
  end

  task automatic put_bit(input logic b);
    rx_drv = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic p,
                            input logic s1, input bit two_stop, input logic s2);
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(d[i]);
    if (has_par) put_bit(p);
    put_bit(s1);
    if (two_stop) put_bit(s2);
  endtask

  task automatic idle(input int n);
    rx_drv = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if0.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if0.valid); end
    checks++; if (if0.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", if0.data_out); end
    checks++; if ({if0.frame_err, if0.parity_err, if0.overrun} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b want 000", {if0.frame_err, if0.parity_err, if0.overrun}); end
    checks++; if ({busy2, busy1, busy0} !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", {busy2, busy1, busy0}); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_single;
    int r0, c0;
    sel = 0; if0.ready = 1'b1;
    r0 = rise[0]; c0 = vcyc[0];
    send_frame(8'hA5, 0, 1'b0, 1'b1, 0, 1'b1);
    idle(20);
    checks++; if (rise[0] - r0 !== 1) begin errors++; $display("FAIL single_words: got %0d want 1", rise[0] - r0); end
    checks++; if (vcyc[0] - c0 !== 1) begin errors++; $display("FAIL single_pulse_len: got %0d want 1", vcyc[0] - c0); end
    checks++; if (cap_d[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", cap_d[0]); end
    checks++; if ({cap_fe[0], cap_pe[0]} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b want 00", {cap_fe[0], cap_pe[0]}); end
    checks++; if ({if0.valid, busy0} !== 2'b00) begin errors++; $display("FAIL single_idle: got %b want 00", {if0.valid, busy0}); end
  endtask

  task automatic test_back_to_back;
    sel = 0; if0.ready = 1'b0;
    send_frame(8'h3C, 0, 1'b0, 1'b1, 0, 1'b1);
    send_frame(8'hC3, 0, 1'b0, 1'b1, 0, 1'b1);
    idle(20);
    checks++; if (if0.valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", if0.valid); end
    checks++; if (if0.data_out !== 8'hC3) begin errors++; $display("FAIL b2b_data: got %h want c3", if0.data_out); end
    checks++; if (if0.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", if0.overrun); end
    checks++; if (if0.frame_err !== 1'b0) begin errors++; $display("FAIL b2b_frame_err: got %b want 0", if0.frame_err); end
    if0.ready = 1'b1;
    @(negedge clk);
    if0.ready = 1'b0;
    checks++; if ({if0.valid, if0.overrun} !== 2'b00) begin errors++; $display("FAIL b2b_accept: got %b want 00", {if0.valid, if0.overrun}); end
    checks++; if (if0.data_out !== 8'hC3) begin errors++; $display("FAIL b2b_data_hold: got %h want c3", if0.data_out); end
    if0.ready = 1'b1;
  endtask

  task automatic test_parity;
    sel = 1; if1.ready = 1'b0;
    send_frame(8'h07, 1, 1'b1, 1'b1, 0, 1'b1);
    idle(20);
    checks++; if ({if1.valid, if1.data_out} !== {1'b1, 8'h07}) begin errors++;
      $display("FAIL par_ok_word: got %b/%h want 1/07", if1.valid, if1.data_out); end
    checks++; if (if1.parity_err !== 1'b0) begin errors++; $display("FAIL par_ok_flag: got %b want 0", if1.parity_err); end
    if1.ready = 1'b1;
    @(negedge clk);
    if1.ready = 1'b0;
    checks++; if (if1.valid !== 1'b0) begin errors++; $display("FAIL par_accept: got %b want 0", if1.valid); end
    send_frame(8'h07, 1, 1'b0, 1'b1, 0, 1'b1);
    idle(20);
    checks++; if ({if1.valid, if1.data_out} !== {1'b1, 8'h07}) begin errors++;
      $display("FAIL par_bad_word: got %b/%h want 1/07", if1.valid, if1.data_out); end
    checks++; if (if1.parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b want 1", if1.parity_err); end
    checks++; if ({if1.frame_err, if1.overrun} !== 2'b00) begin errors++;
      $display("FAIL par_bad_other: got %b want 00", {if1.frame_err, if1.overrun}); end
    if1.ready = 1'b1;
    @(negedge clk);
    sel = 0;
  endtask

  task automatic test_break;
    int r2;
    sel = 2; if2.ready = 1'b0;
    r2 = rise[2];
    send_frame(8'h55, 0, 1'b0, 1'b1, 1, 1'b0);
    checks++; if ({if2.valid, if2.data_out, if2.frame_err} !== {1'b1, 8'h55, 1'b1}) begin errors++;
      $display("FAIL brk_word: got %b/%h/%b want 1/55/1", if2.valid, if2.data_out, if2.frame_err); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL brk_busy_early: got %b want 1", busy2); end
    repeat (40 * CPB) @(negedge clk);
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL brk_busy_held: got %b want 1", busy2); end
    checks++; if (rise[2] - r2 !== 1) begin errors++; $display("FAIL brk_words: got %0d want 1", rise[2] - r2); end
    checks++; if (if2.overrun !== 1'b0) begin errors++; $display("FAIL brk_overrun: got %b want 0", if2.overrun); end
    idle(6);
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL brk_release: got %b want 0", busy2); end
    if2.ready = 1'b1;
    @(negedge clk);
    checks++; if ({if2.valid, if2.frame_err} !== 2'b00) begin errors++;
      $display("FAIL brk_accept: got %b want 00", {if2.valid, if2.frame_err}); end
    sel = 0;
  endtask

  task automatic test_glitch;
    int  r0;
    bit  seen = 0;
    sel = 0; if0.ready = 1'b1;
    r0 = rise[0];
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy0) seen = 1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b want 1", seen); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b want 0", busy0); end
    checks++; if (rise[0] - r0 !== 0) begin errors++; $display("FAIL glitch_no_word: got %0d want 0", rise[0] - r0); end
    send_frame(8'h81, 0, 1'b0, 1'b1, 0, 1'b1);
    idle(20);
    checks++; if (rise[0] - r0 !== 1) begin errors++; $display("FAIL glitch_next_words: got %0d want 1", rise[0] - r0); end
    checks++; if (cap_d[0] !== 8'h81) begin errors++; $display("FAIL glitch_next_data: got %h want 81", cap_d[0]); end
  endtask

  task automatic test_reset_mid;
    int r0;
    sel = 0; if0.ready = 1'b1;
    r0 = rise[0];
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy0); end
    rx_drv = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({busy0, if0.valid, if0.overrun, if0.frame_err, if0.parity_err} !== 5'b0) begin errors++;
      $display("FAIL rmid_outputs: got %b want 00000", {busy0, if0.valid, if0.overrun, if0.frame_err, if0.parity_err}); end
    checks++; if (if0.data_out !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", if0.data_out); end
    idle(3 * CPB);
    checks++; if (rise[0] - r0 !== 0) begin errors++; $display("FAIL rmid_no_word: got %0d want 0", rise[0] - r0); end
    send_frame(8'hF0, 0, 1'b0, 1'b1, 0, 1'b1);
    idle(20);
    checks++; if (rise[0] - r0 !== 1) begin errors++; $display("FAIL rmid_next_words: got %0d want 1", rise[0] - r0); end
    checks++; if ({cap_d[0], cap_fe[0], cap_pe[0]} !== {8'hF0, 2'b00}) begin errors++;
      $display("FAIL rmid_next_word: got %h/%b%b want f0/00", cap_d[0], cap_fe[0], cap_pe[0]); end
  endtask

  initial begin
    if0.ready = 1'b1;
    if1.ready = 1'b0;
    if2.ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_parity;
    test_break;
    test_glitch;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
